// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive-side byte FIFO between a UART receiver and its consumer
//
// Purpose:
//   Captures each byte from the UART receiver on its one-cycle i_wr_valid strobe.
//   Bytes go into a DEPTH-entry circular buffer. The buffer presents its head byte
//   show-ahead on a valid/ready read port and keeps a sticky overflow flag for dropped
//   bytes.
//
// Optional feature:
//   UART_RX_FIFO_ERR_TAG_EN
//     - Defined: each entry also stores the parity and framing error tags of its byte.
//       Those tags come back on o_rd_parity_err / o_rd_frame_err.
//     - Undefined: the error inputs are ignored and both error outputs read 0.
//     - The port list is the same in both builds.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset; discards all buffered bytes
//   i_wr_data        received byte
//   i_wr_valid       one-cycle push strobe
//   i_wr_parity_err  parity error tag for i_wr_data
//   i_wr_frame_err   framing error tag for i_wr_data
//   o_rd_data        head byte, meaningful while o_rd_valid=1
//   o_rd_parity_err  head entry's parity tag
//   o_rd_frame_err   head entry's framing tag
//   o_rd_valid       FIFO not empty
//   i_rd_ready       consumer accepts head; pop when o_rd_valid & i_rd_ready
//   o_count          occupancy, 0..DEPTH
//   o_full           o_count == DEPTH
//   o_overflow       sticky: a push was dropped
//   i_overflow_clr   clears o_overflow (a same-cycle drop wins)

module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_wr_valid,
  input  logic                       i_wr_parity_err,
  input  logic                       i_wr_frame_err,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_rd_parity_err,
  output logic                       o_rd_frame_err,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  localparam int EW = DATA_W + 2;
`else
  localparam int EW = DATA_W;
`endif

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_rd_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_rd_valid = (r_count != '0);
  assign w_pop      = w_rd_valid & i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept a byte.
  assign w_push     = i_wr_valid & (~w_full | w_pop);
  assign w_drop     = i_wr_valid & w_full & ~w_pop;

`ifdef UART_RX_FIFO_ERR_TAG_EN
  assign w_wr_entry      = {i_wr_parity_err, i_wr_frame_err, i_wr_data};
  assign w_head          = r_mem[r_rd_ptr];
  assign o_rd_data       = w_head[DATA_W-1:0];
  assign o_rd_parity_err = w_head[DATA_W+1];
  assign o_rd_frame_err  = w_head[DATA_W];
`else
  logic w_unused_err;
  assign w_unused_err    = i_wr_parity_err ^ i_wr_frame_err;
  assign w_wr_entry      = i_wr_data;
  assign w_head          = r_mem[r_rd_ptr];
  assign o_rd_data       = w_head;
  assign o_rd_parity_err = 1'b0;
  assign o_rd_frame_err  = 1'b0;
`endif

  // Storage needs no reset: nothing is read while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // Pointers wrap from DEPTH-1 to 0 by natural overflow (DEPTH is a power of two).
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_rd_valid = w_rd_valid;
  assign o_full     = w_full;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
